// File: rtl/pet_ram_arbiter.sv
// Video/CPU arbiter for the single-port PET screen RAM: video fetch has priority,
// with a bounded-starvation escape so a waiting CPU request gets every (STARVE_MAX+1)th slot.
module pet_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic              grant_vid;
    logic              grant_cpu;

    logic [SW-1:0]     starve_q,    starve_d;
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Tag pipeline: stage 1 follows the RAM command, stage 2 marks returning read data.
    logic              rd1_vld_q,   rd1_vld_d;
    logic              rd1_cpu_q,   rd1_cpu_d;
    logic              vid_rv_q,    vid_rv_d;
    logic              cpu_rv_q,    cpu_rv_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    // Grants are gated by reset_n so no ack can escape while the block is held in reset.
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (reset_n) begin
            if (vid_req && !(cpu_req && (starve_q == STARVE_LIM))) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || grant_cpu) begin
            starve_d = '0;
        end else if (grant_vid && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        ram_en_d    = grant_vid | grant_cpu;
        ram_we_d    = grant_cpu & cpu_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_vid) begin
            ram_addr_d = vid_addr;
        end else if (grant_cpu) begin
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
        end

        rd1_vld_d = grant_vid | (grant_cpu & ~cpu_we);
        rd1_cpu_d = grant_cpu;
        vid_rv_d  = rd1_vld_q & ~rd1_cpu_q;
        cpu_rv_d  = rd1_vld_q &  rd1_cpu_q;

        vid_rdata_d = vid_rv_q ? ram_rdata : vid_rdata_q;
        cpu_rdata_d = cpu_rv_q ? ram_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd1_vld_q   <= 1'b0;
            rd1_cpu_q   <= 1'b0;
            vid_rv_q    <= 1'b0;
            cpu_rv_q    <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_cpu_q   <= rd1_cpu_d;
            vid_rv_q    <= vid_rv_d;
            cpu_rv_q    <= cpu_rv_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign vid_ack    = grant_vid;
    assign cpu_ack    = grant_cpu;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign vid_rvalid = vid_rv_q;
    assign cpu_rvalid = cpu_rv_q;

    // The RAM's own output register is the data register for the N+2 beat; the local
    // copies only hold the last returned word while rvalid is low.
    assign vid_rdata  = vid_rv_q ? ram_rdata : vid_rdata_q;
    assign cpu_rdata  = cpu_rv_q ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_pet_ram_arbiter.sv
// Directed and random checks for pet_ram_arbiter against a behavioural
// single-port synchronous RAM with one-cycle read latency.
module tb_pet_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pet_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        #1;
        check_eq("preload_ack", cpu_ack, 1);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick;
    endtask

    task automatic vid_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick;
        vid_req = 1'b1; vid_addr = a;
        #1;
        check_eq("vrd_ack", vid_ack, 1);
        check_eq("vrd_cpu_ack", cpu_ack, 0);
        tick;
        vid_req = 1'b0;
        #1;
        check_eq("vrd_ram_en", ram_en, 1);
        check_eq("vrd_ram_addr", ram_addr, a);
        check_eq("vrd_ram_we", ram_we, 0);
        check_eq("vrd_rvalid_n1", vid_rvalid, 0);
        tick;
        check_eq("vrd_rvalid_n2", vid_rvalid, 1);
        check_eq("vrd_rdata", vid_rdata, d);
        check_eq("vrd_cpu_rvalid", cpu_rvalid, 0);
        check_eq("vrd_ram_en_idle", ram_en, 0);
        tick;
        check_eq("vrd_rvalid_n3", vid_rvalid, 0);
        check_eq("vrd_rdata_hold", vid_rdata, d);
    endtask

    initial begin
        int rd_grants;
        int rvalids;
        int run;
        bit v_drop;
        bit c_drop;

        reset_n = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state, with requests asserted to show acks are suppressed.
        tick; tick;
        vid_req = 1'b1; cpu_req = 1'b1;
        #1;
        check_eq("rst_vid_ack", vid_ack, 0);
        check_eq("rst_cpu_ack", cpu_ack, 0);
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_vid_rvalid", vid_rvalid, 0);
        check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
        check_eq("rst_vid_rdata", vid_rdata, 0);
        check_eq("rst_cpu_rdata", cpu_rdata, 0);
        vid_req = 1'b0; cpu_req = 1'b0;
        tick;
        reset_n = 1'b1;

        cpu_write(10'h3E7, 8'h41);
        cpu_write(10'h020, 8'h00);

        // Plain video read.
        vid_read(10'h3E7, 8'h41);

        // CPU write then read back.
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 8'h5A;
        #1;
        check_eq("cwr_ack", cpu_ack, 1);
        check_eq("cwr_vid_ack", vid_ack, 0);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check_eq("cwr_ram_en", ram_en, 1);
        check_eq("cwr_ram_we", ram_we, 1);
        check_eq("cwr_ram_addr", ram_addr, 10'h010);
        check_eq("cwr_ram_wdata", ram_wdata, 8'h5A);
        tick;
        check_eq("cwr_no_rvalid", cpu_rvalid, 0);
        check_eq("cwr_no_vrvalid", vid_rvalid, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        #1;
        check_eq("crd_ack", cpu_ack, 1);
        tick;
        cpu_req = 1'b0;
        #1;
        check_eq("crd_ram_en", ram_en, 1);
        check_eq("crd_ram_we", ram_we, 0);
        tick;
        check_eq("crd_rvalid", cpu_rvalid, 1);
        check_eq("crd_rdata", cpu_rdata, 8'h5A);
        check_eq("crd_no_vrvalid", vid_rvalid, 0);
        tick;
        check_eq("crd_rvalid_off", cpu_rvalid, 0);

        // Same-address collision: video reads the old value, CPU writes after.
        tick;
        vid_req = 1'b1; vid_addr = 10'h020;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 8'hFF;
        #1;
        check_eq("col_vid_ack", vid_ack, 1);
        check_eq("col_cpu_wait", cpu_ack, 0);
        tick;
        vid_req = 1'b0;
        #1;
        check_eq("col_cpu_ack", cpu_ack, 1);
        check_eq("col_vid_ack_off", vid_ack, 0);
        check_eq("col_rd_addr", ram_addr, 10'h020);
        check_eq("col_rd_we", ram_we, 0);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check_eq("col_vrvalid", vid_rvalid, 1);
        check_eq("col_vrdata_old", vid_rdata, 8'h00);
        check_eq("col_wr_we", ram_we, 1);
        check_eq("col_wr_data", ram_wdata, 8'hFF);
        tick;
        check_eq("col_mem_new", mem[10'h020], 8'hFF);
        check_eq("col_no_crvalid", cpu_rvalid, 0);

        // Starvation: both held, expect 4 video grants then 1 CPU grant, repeating.
        tick;
        vid_req = 1'b1; vid_addr = 10'h3E7;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        for (int k = 0; k < 15; k++) begin
            #1;
            check_eq("stv_vid_ack", vid_ack, (k % 5) != 4);
            check_eq("stv_cpu_ack", cpu_ack, (k % 5) == 4);
            tick;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tick; tick; tick;

        // Reset one cycle after a video grant: the in-flight read must vanish.
        vid_req = 1'b1; vid_addr = 10'h3E7;
        #1;
        check_eq("rmr_ack", vid_ack, 1);
        tick;
        vid_req = 1'b0; reset_n = 1'b0; cpu_req = 1'b1;
        #1;
        check_eq("rmr_ram_en", ram_en, 0);
        check_eq("rmr_ram_addr", ram_addr, 0);
        check_eq("rmr_cpu_ack", cpu_ack, 0);
        check_eq("rmr_vrvalid", vid_rvalid, 0);
        for (int k = 0; k < 2; k++) begin
            tick;
            check_eq("rmr_vrvalid_rst", vid_rvalid, 0);
            check_eq("rmr_vrdata_rst", vid_rdata, 0);
        end
        cpu_req = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            check_eq("rmr_vrvalid_post", vid_rvalid, 0);
            check_eq("rmr_ram_en_post", ram_en, 0);
        end
        vid_read(10'h3E7, 8'h41);
        tick; tick;

        // Random traffic with request/ack handshake.
        rd_grants = 0; rvalids = 0; run = 0; v_drop = 0; c_drop = 0;
        for (int c = 0; c < 400; c++) begin
            tick;
            if (v_drop) vid_req = 1'b0;
            if (c_drop) cpu_req = 1'b0;
            if (!vid_req && ($urandom_range(0, 1) == 1)) begin
                vid_req  = 1'b1;
                vid_addr = AW'($urandom_range(0, (1 << AW) - 1));
            end
            if (!cpu_req && ($urandom_range(0, 2) != 0)) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, (1 << AW) - 1));
                cpu_wdata = DW'($urandom_range(0, 255));
            end
            #1;
            check_eq("rnd_ack_onehot", vid_ack & cpu_ack, 0);
            if (cpu_ack || !cpu_req) run = 0;
            else if (vid_ack)        run++;
            check_eq("rnd_starve_bound", run > 4, 0);
            rd_grants += int'(vid_ack) + int'(cpu_ack & ~cpu_we);
            rvalids   += int'(vid_rvalid) + int'(cpu_rvalid);
            v_drop = vid_ack;
            c_drop = cpu_ack;
        end
        tick;
        vid_req = 1'b0; cpu_req = 1'b0;
        #1;
        rd_grants += int'(vid_ack) + int'(cpu_ack & ~cpu_we);
        rvalids   += int'(vid_rvalid) + int'(cpu_rvalid);
        for (int k = 0; k < 3; k++) begin
            tick;
            rvalids += int'(vid_rvalid) + int'(cpu_rvalid);
        end
        check_eq("rnd_rvalid_count", rvalids, rd_grants);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
